// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: multi-way traffic-light phase controller.
// Optional flash mode is built when FLASH_MODE_EN is defined.
module traffic_phase_ctrl #(
   parameter int NUM_WAYS     = 3,
   parameter int PRESCALE_MAX = 15,
   parameter int TIMER_W      = 6,
   parameter int GREEN_TIME   = 20,
   parameter int AMBER_TIME   = 3,
   parameter int ALLRED_TIME  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                sync_clr,
   input  logic [NUM_WAYS-1:0] req,
`ifdef FLASH_MODE_EN
   input  logic                flash_req,
`endif
   output logic [NUM_WAYS-1:0] green,
   output logic [NUM_WAYS-1:0] amber,
   output logic [NUM_WAYS-1:0] red,
   output logic [1:0]          active_way,
   output logic                tick,
   output logic                phase_start
);

   localparam int PW =
      (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
   localparam logic [PW-1:0] P_MAX = PW'(PRESCALE_MAX);
   localparam logic [TIMER_W-1:0] T_GREEN =
      TIMER_W'(GREEN_TIME - 1);
   localparam logic [TIMER_W-1:0] T_AMBER =
      TIMER_W'(AMBER_TIME - 1);
   localparam logic [TIMER_W-1:0] T_ALLRED =
      TIMER_W'(ALLRED_TIME - 1);
   localparam logic [NUM_WAYS-1:0] WAY0 = NUM_WAYS'(1);

   typedef enum logic [1:0] {
      S_GREEN  = 2'd0,
      S_AMBER  = 2'd1,
      S_ALLRED = 2'd2
`ifdef FLASH_MODE_EN
      , S_FLASH = 2'd3
`endif
   } state_t;

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [1:0]           active_q, active_d;
   logic [PW-1:0]        presc_q;
   logic [NUM_WAYS-1:0]  req_lat_q, req_lat_d;
   logic [NUM_WAYS-1:0]  clr_mask, lat_sh;
   logic [NUM_WAYS-1:0]  green_d, amber_d, red_d;
   logic [1:0]           sel;
   logic                 found, other_dem, enter;
   int                   rr_idx;
`ifdef FLASH_MODE_EN
   logic                 flash_on_q, flash_on_d;
   logic                 flash_exit_q, flash_exit_d;
`endif

   function automatic logic [NUM_WAYS-1:0] way_oh(
      input logic [1:0] w
   );
      way_oh = WAY0 << w;
   endfunction

   assign tick = enable && !sync_clr && (presc_q == P_MAX);
   assign active_way = active_q;
   assign other_dem = |(req_lat_q & ~way_oh(active_q));

   // Prescaler: free-running tick source, held when disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else if (sync_clr) begin
         presc_q <= '0;
      end else if (enable) begin
         presc_q <= (presc_q == P_MAX) ? '0 : presc_q + PW'(1);
      end
   end

   // Round-robin pick of the next way with latched demand
   always_comb begin
      sel = 2'((int'(active_q) + 1) % NUM_WAYS);
      found = 1'b0;
      rr_idx = 0;
      lat_sh = '0;
      for (int k = 1; k <= NUM_WAYS; k++) begin
         rr_idx = (int'(active_q) + k) % NUM_WAYS;
         lat_sh = req_lat_q >> rr_idx;
         if (!found && lat_sh[0]) begin
            sel = 2'(rr_idx);
            found = 1'b1;
         end
      end
   end

   // Next-state, timer, way and lamp decode
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      active_d = active_q;
      enter    = 1'b0;
      clr_mask = '0;
`ifdef FLASH_MODE_EN
      flash_on_d   = flash_on_q;
      flash_exit_d = flash_exit_q;
`endif
      if (tick) begin
         case (state_q)
            S_GREEN: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - TIMER_W'(1);
               end else if (other_dem) begin
                  state_d = S_AMBER;
                  timer_d = T_AMBER;
                  enter   = 1'b1;
               end
            end
            S_AMBER: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - TIMER_W'(1);
               end else begin
                  state_d = S_ALLRED;
                  timer_d = T_ALLRED;
                  enter   = 1'b1;
               end
            end
            S_ALLRED: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - TIMER_W'(1);
`ifdef FLASH_MODE_EN
               end else if (flash_req) begin
                  state_d    = S_FLASH;
                  flash_on_d = 1'b1;
                  enter      = 1'b1;
               end else begin
                  state_d      = S_GREEN;
                  timer_d      = T_GREEN;
                  active_d     = flash_exit_q ? 2'd0 : sel;
                  flash_exit_d = 1'b0;
                  clr_mask     = way_oh(active_d);
                  enter        = 1'b1;
               end
            end
            S_FLASH: begin
               if (!flash_req) begin
                  state_d      = S_ALLRED;
                  timer_d      = T_ALLRED;
                  flash_on_d   = 1'b0;
                  flash_exit_d = 1'b1;
                  enter        = 1'b1;
               end else begin
                  flash_on_d = ~flash_on_q;
               end
            end
`else
               end else begin
                  state_d  = S_GREEN;
                  timer_d  = T_GREEN;
                  active_d = sel;
                  clr_mask = way_oh(sel);
                  enter    = 1'b1;
               end
            end
`endif
            default: state_d = S_GREEN;
         endcase
      end
      req_lat_d = (req_lat_q | req) & ~clr_mask;
      green_d = '0;
      amber_d = '0;
      red_d   = '1;
      case (state_d)
         S_GREEN: begin
            green_d = way_oh(active_d);
            red_d   = ~way_oh(active_d);
         end
         S_AMBER: begin
            amber_d = way_oh(active_d);
            red_d   = ~way_oh(active_d);
         end
`ifdef FLASH_MODE_EN
         S_FLASH: begin
            red_d   = '0;
            amber_d = {NUM_WAYS{flash_on_d}};
         end
`endif
         default: red_d = '1;
      endcase
   end

   // Phase state, demand latch and registered lamps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_GREEN;
         timer_q     <= T_GREEN;
         active_q    <= 2'd0;
         req_lat_q   <= '0;
         phase_start <= 1'b0;
         green       <= WAY0;
         amber       <= '0;
         red         <= ~WAY0;
`ifdef FLASH_MODE_EN
         flash_on_q   <= 1'b0;
         flash_exit_q <= 1'b0;
`endif
      end else if (sync_clr) begin
         state_q     <= S_GREEN;
         timer_q     <= T_GREEN;
         active_q    <= 2'd0;
         req_lat_q   <= '0;
         phase_start <= 1'b0;
         green       <= WAY0;
         amber       <= '0;
         red         <= ~WAY0;
`ifdef FLASH_MODE_EN
         flash_on_q   <= 1'b0;
         flash_exit_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         active_q    <= active_d;
         req_lat_q   <= req_lat_d;
         phase_start <= enter;
         green       <= green_d;
         amber       <= amber_d;
         red         <= red_d;
`ifdef FLASH_MODE_EN
         flash_on_q   <= flash_on_d;
         flash_exit_q <= flash_exit_d;
`endif
      end
   end

endmodule
